regfile_mp: RTL

Parametrised multi-port register file, successor to the 16x16 single-write/dual-read register file. Configurable width, depth and read-port count. Adds a second write port with defined priority, registered reads with valid flags, an optional hardwired-zero entry, and a post-reset clear sequencer. Sits between the decode stage (read addresses) and the writeback stage (write ports) of the datapath.

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_clear_seq.sv | 47 ++++
 rtl/regfile_mp.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_t;

  localparam int MAX_RD    = 4;
  localparam int MAX_WIDTH = 64;

  localparam logic [MAX_WIDTH-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the datapath and regfile_mp: two write ports, NUM_RD read ports, ready.
// Handshake: there is no per-request ready. A write or read request is accepted in any cycle where
// ready=1 and its enable is high; rd_valid[i] is asserted exactly one cycle after an accepted read.
interface regfile_mp_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                    wr0_en;
  logic [AW-1:0]           wr0_addr;
  logic [WIDTH-1:0]        wr0_data;
  logic                    wr1_en;
  logic [AW-1:0]           wr1_addr;
  logic [WIDTH-1:0]        wr1_data;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;
  logic                    ready;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, ready
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// CLEAR/RUN sequencer: after reset, sweeps every entry to zero once, then holds in RUN.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           ready,
  output logic           clr_we,
  output logic [AW-1:0]  clr_addr,
  output regfile_state_t state
);

  regfile_state_t state_nxt;
  logic [AW-1:0]  cnt;
  logic [AW-1:0]  cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    ready     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nxt = RUN;
        else                       cnt_nxt   = cnt + AW'(1);
      end
      RUN: ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two write ports (port 1 wins), NUM_RD registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads of the same address.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 0
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_if.slave    bus,
  output regfile_state_t state
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          we0;
  logic          we1;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (state)
  );

  assign bus.ready = ready;

  // Writes to the hardwired-zero entry are dropped before they reach the array or the bypass.
  assign we0 = bus.wr0_en && ready && !((ZERO_REG0 != 0) && (bus.wr0_addr == '0));
  assign we1 = bus.wr1_en && ready && !((ZERO_REG0 != 0) && (bus.wr1_addr == '0));

  // Port 1 is written after port 0 so it takes the entry on an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= ZERO_DATA[WIDTH-1:0];
    end else begin
      if (we0) mem[bus.wr0_addr] <= bus.wr0_data;
      if (we1) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  logic [AW-1:0]    ra    [NUM_RD];
  logic [WIDTH-1:0] sel   [NUM_RD];
  logic [WIDTH-1:0] q     [NUM_RD];
  logic             v     [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign ra[g] = bus.rd_addr[g*AW +: AW];

    always_comb begin
      sel[g] = mem[ra[g]];
`ifdef REGFILE_BYPASS_EN
      if (we0 && (bus.wr0_addr == ra[g])) sel[g] = bus.wr0_data;
      if (we1 && (bus.wr1_addr == ra[g])) sel[g] = bus.wr1_data;
`endif
      if ((ZERO_REG0 != 0) && (ra[g] == '0)) sel[g] = ZERO_DATA[WIDTH-1:0];
    end

    // Data holds while idle; only the valid flag tracks the request.
    always_ff @(posedge clk) begin
      if (rst) begin
        q[g] <= ZERO_DATA[WIDTH-1:0];
        v[g] <= 1'b0;
      end else begin
        v[g] <= bus.rd_en[g] && ready;
        if (bus.rd_en[g] && ready) q[g] <= sel[g];
      end
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*WIDTH +: WIDTH] = q[i];
      bus.rd_valid[i]               = v[i];
    end
  end

endmodule
